// File: rtl/uart_rx_parity_if.sv
// Received-byte bus from the UART receiver to the register/FIFO logic.
// The receiver drives the bus; the consumer samples it.
interface uart_rx_parity_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 rx_done;
    logic [DATA_BITS-1:0] d_out;
    logic                 parity_err;
    logic                 frame_err;

    modport master (
        output rx_done,
        output d_out,
        output parity_err,
        output frame_err
    );

    modport slave (
        input rx_done,
        input d_out,
        input parity_err,
        input frame_err
    );
endinterface

// File: rtl/uart_rx_parity.sv
// UART receiver: start, DATA_BITS data (LSB first), parity, stop; 16x oversampled.
// Reports each byte with parity/framing status as a one-cycle strobe.
module uart_rx_parity #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              b_tick,
    input  logic              rx,
    input  logic              PARITYSEL,
    uart_rx_parity_if.master  rx_if
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned N_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] S_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] S_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [N_W-1:0]   N_LAST = N_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     s_cnt_q, s_cnt_d;
    logic [N_W-1:0]       n_q, n_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 par_sel_q, par_sel_d;
    logic                 rx_done_q, rx_done_d;
    logic [DATA_BITS-1:0] d_out_q, d_out_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;

    logic                 rx_meta;
    logic                 rx_s;

    // Two-flop synchronizer; idles high so reset never looks like a start edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            s_cnt_q      <= '0;
            n_q          <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            par_sel_q    <= 1'b0;
            rx_done_q    <= 1'b0;
            d_out_q      <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_cnt_q      <= s_cnt_d;
            n_q          <= n_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            par_sel_q    <= par_sel_d;
            rx_done_q    <= rx_done_d;
            d_out_q      <= d_out_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        s_cnt_d      = s_cnt_q;
        n_d          = n_q;
        shift_d      = shift_q;
        par_d        = par_q;
        par_sel_d    = par_sel_q;
        rx_done_d    = 1'b0;
        d_out_d      = d_out_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d   = START;
                    s_cnt_d   = '0;
                    par_sel_d = PARITYSEL;
                end
            end
            START: begin
                // Re-check the line at mid start bit to reject glitches
                if (b_tick) begin
                    if (s_cnt_q == S_HALF) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_cnt_d = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + CNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (b_tick) begin
                    if (s_cnt_q == S_LAST) begin
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        s_cnt_d = '0;
                        if (n_q == N_LAST) begin
                            state_d = PARITY;
                        end else begin
                            n_d = n_q + N_W'(1);
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (b_tick) begin
                    if (s_cnt_q == S_LAST) begin
                        par_d   = rx_s;
                        s_cnt_d = '0;
                        state_d = STOP;
                    end else begin
                        s_cnt_d = s_cnt_q + CNT_W'(1);
                    end
                end
            end
            STOP: begin
                if (b_tick) begin
                    if (s_cnt_q == S_LAST) begin
                        rx_done_d    = 1'b1;
                        d_out_d      = shift_q;
                        parity_err_d = ((^shift_q) ^ par_q) != par_sel_q;
                        frame_err_d  = ~rx_s;
                        s_cnt_d      = '0;
                        state_d      = rx_s ? IDLE : BREAK;
                    end else begin
                        s_cnt_d = s_cnt_q + CNT_W'(1);
                    end
                end
            end
            BREAK: begin
                // A held-low line must not be mistaken for a new start bit
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_if.rx_done    = rx_done_q;
    assign rx_if.d_out      = d_out_q;
    assign rx_if.parity_err = parity_err_q;
    assign rx_if.frame_err  = frame_err_q;

    a_done_pulse: assert property (@(posedge clk) disable iff (!resetn)
        rx_done_q |=> !rx_done_q);

    a_state_legal: assert property (@(posedge clk) disable iff (!resetn)
        state_q inside {IDLE, START, DATA, PARITY, STOP, BREAK});

    a_s_cnt_range: assert property (@(posedge clk) disable iff (!resetn)
        32'(s_cnt_q) < OVERSAMPLE);

endmodule

// File: tb/tb_uart_rx_parity.sv
// Scoreboarded bench for uart_rx_parity: a line driver pushes expected bytes,
// a monitor pops and compares on every rx_done strobe.
module tb_uart_rx_parity;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned TICK_DIV   = 4;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    logic b_tick = 1'b0;
    logic rx;
    logic PARITYSEL;
    logic abort;

    int   tick_cnt = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    uart_rx_parity_if #(.DATA_BITS(DATA_BITS)) rx_if ();

    uart_rx_parity #(
        .DATA_BITS  (DATA_BITS),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .b_tick    (b_tick),
        .rx        (rx),
        .PARITYSEL (PARITYSEL),
        .rx_if     (rx_if)
    );

    always #5 clk = ~clk;

    // Baud tick: one clk-wide pulse every TICK_DIV clocks
    always @(negedge clk) begin
        tick_cnt = (tick_cnt == TICK_DIV - 1) ? 0 : tick_cnt + 1;
        b_tick   = (tick_cnt == 0);
    end

    function automatic void chk(string name, int unsigned act, int unsigned req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    // Parity bit a correct transmitter would send
    function automatic logic good_par(logic [7:0] d, logic psel);
        return logic'(($countones(d) % 2) != 0) ^ psel;
    endfunction

    // Monitor: every strobe must match the oldest outstanding frame
    always @(negedge clk) begin
        if (rx_if.rx_done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_strobe: got d_out=%0h, expected no strobe at %0t",
                         rx_if.d_out, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("d_out", 32'(rx_if.d_out), 32'(e.data));
                chk("parity_err", 32'(rx_if.parity_err), 32'(e.perr));
                chk("frame_err", 32'(rx_if.frame_err), 32'(e.ferr));
            end
        end
    end

    task automatic wait_tick();
        do @(posedge clk); while (!b_tick);
        #1;
    endtask

    task automatic line(logic level, int unsigned ticks);
        rx = level;
        repeat (ticks) wait_tick();
    endtask

    // Drive one frame; expectation comes from counting ones, not from the DUT
    task automatic send(logic [7:0] d, logic par, logic stop, logic psel, bit expect_it);
        logic [10:0] bits;
        exp_t        e;
        bits = {stop, par, d, 1'b0};
        PARITYSEL = psel;
        if (expect_it) begin
            e.data = d;
            e.perr = ((($countones(d) + int'(par)) % 2) == 1) != psel;
            e.ferr = !stop;
            exp_q.push_back(e);
        end
        for (int b = 0; b < 11; b++) begin
            rx = bits[b];
            for (int k = 0; k < int'(OVERSAMPLE); k++) begin
                if (abort) begin
                    rx = 1'b1;
                    return;
                end
                wait_tick();
            end
            if (b == 0) PARITYSEL = logic'($urandom_range(0, 1));
        end
    endtask

    task automatic check_outputs(string tag, logic [7:0] d, logic pe, logic fe);
        chk({tag, "_d_out"}, 32'(rx_if.d_out), 32'(d));
        chk({tag, "_parity_err"}, 32'(rx_if.parity_err), 32'(pe));
        chk({tag, "_frame_err"}, 32'(rx_if.frame_err), 32'(fe));
    endtask

    initial begin
        resetn    = 1'b0;
        rx        = 1'b1;
        PARITYSEL = 1'b0;
        abort     = 1'b0;
        repeat (4) @(negedge clk);
        check_outputs("reset", 8'h00, 1'b0, 1'b0);
        chk("reset_rx_done", 32'(rx_if.rx_done), 0);
        @(posedge clk);
        #1 resetn = 1'b1;
        line(1'b1, 2 * OVERSAMPLE);

        // Clean frame, then wrong parity bit under even and odd selection
        send(8'hA5, 1'b0, 1'b1, 1'b0, 1'b1);
        send(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1);
        send(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);

        // Break: bad stop bit followed by a long low line, then recovery
        send(8'h3C, good_par(8'h3C, 1'b0), 1'b0, 1'b0, 1'b1);
        line(1'b0, 3 * OVERSAMPLE);
        line(1'b1, 2 * OVERSAMPLE);
        send(8'h81, good_par(8'h81, 1'b0), 1'b1, 1'b0, 1'b1);

        // Short low glitch must be rejected without touching outputs
        line(1'b1, OVERSAMPLE);
        line(1'b0, 4);
        line(1'b1, 3 * OVERSAMPLE);
        check_outputs("glitch", 8'h81, 1'b0, 1'b0);

        // Back-to-back frames, odd parity
        send(8'h00, good_par(8'h00, 1'b1), 1'b1, 1'b1, 1'b1);
        send(8'hFF, good_par(8'hFF, 1'b1), 1'b1, 1'b1, 1'b1);
        send(8'h55, good_par(8'h55, 1'b1), 1'b1, 1'b1, 1'b1);

        // Reset in the middle of data bit 4
        fork
            send(8'hC3, good_par(8'hC3, 1'b0), 1'b1, 1'b0, 1'b0);
            begin
                repeat (5 * OVERSAMPLE + OVERSAMPLE / 2) wait_tick();
                abort  = 1'b1;
                resetn = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        check_outputs("midreset", 8'h00, 1'b0, 1'b0);
        chk("midreset_rx_done", 32'(rx_if.rx_done), 0);
        @(posedge clk);
        #1;
        abort  = 1'b0;
        resetn = 1'b1;
        line(1'b1, 2 * OVERSAMPLE);
        send(8'h12, good_par(8'h12, 1'b0), 1'b1, 1'b0, 1'b1);

        // Randomized frames: occasional bad parity, bad stop, varying gaps
        for (int i = 0; i < 20; i++) begin
            logic [7:0] d;
            logic       psel, par, stop;
            d    = 8'($urandom_range(0, 255));
            psel = logic'($urandom_range(0, 1));
            par  = good_par(d, psel) ^ logic'($urandom_range(0, 3) == 0);
            stop = logic'($urandom_range(0, 7) != 0);
            send(d, par, stop, psel, 1'b1);
            if (!stop) line(1'b1, OVERSAMPLE);
            line(1'b1, OVERSAMPLE * $urandom_range(0, 2));
        end

        line(1'b1, 2 * OVERSAMPLE);
        for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(negedge clk);
        chk("frames_outstanding", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_parity.md
Name: uart_rx_parity

Overview:
- Serial receiver that sits directly downstream of the UART transmitter.
- Recovers frames of 1 start bit, 8 data bits (LSB first), 1 parity bit and 1 stop bit from the RS-232 line.
- Uses the shared 16x-oversampling baud tick.
- Presents each received byte with parity and framing status to the AHB UART register/FIFO logic as a one-cycle strobe.

Parameters:
- DATA_BITS, 8: data bits per frame; counter widths are derived from it.
- OVERSAMPLE, 16: b_tick pulses per bit period; must be even and at least 4.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- b_tick  input  1  baud tick, one clk-cycle pulse at 16x the bit rate
- rx  input  1  asynchronous serial line, idles high
- PARITYSEL  input  1  1 = odd parity, 0 = even parity
- rx_done  output  1  one-cycle strobe: frame complete, d_out and error flags valid
- d_out  output  DATA_BITS  received byte, held until the next rx_done
- parity_err  output  1  parity mismatch on the last frame, held until the next rx_done
- frame_err  output  1  stop bit sampled low on the last frame, held until the next rx_done

Behaviour:
- Reset: resetn is asynchronous and active-low; the clock is clk. On reset, state = IDLE, rx_done = 0, d_out = 0, parity_err = 0, frame_err = 0, tick and bit counters = 0, synchronizer flops = 1.
- Reset mid-frame aborts the frame with no rx_done.
- Input sync: rx passes through a 2-flop synchronizer to give rx_s. All decisions use rx_s only.
- Tick counter: s_cnt (4 bits) advances only on b_tick. There is no activity between ticks.
- IDLE: on rx_s == 0, go to START, clear s_cnt, and latch PARITYSEL into par_sel_q. PARITYSEL changes mid-frame are ignored.
- START: on b_tick with s_cnt == OVERSAMPLE/2-1 (7), sample rx_s.
  - If rx_s == 0: go to DATA, clear s_cnt and bit counter n.
  - If rx_s == 1 (glitch or false start): return to IDLE with no strobe.
  - Otherwise s_cnt++.
- DATA: on b_tick with s_cnt == 15, shift rx_s into the MSB of shift_reg (right shift) and clear s_cnt.
  - If n == DATA_BITS-1, go to PARITY; else n++.
  - Sample points are at bit centres.
- PARITY: on b_tick with s_cnt == 15, capture par_q = rx_s, clear s_cnt, go to STOP.
- STOP: on b_tick with s_cnt == 15, sample the stop bit. In the same clock edge:
  - d_out <= shift_reg.
  - parity_err <= ((^shift_reg) ^ par_q) != par_sel_q. That is, total ones across data and parity must be odd when PARITYSEL = 1 and even when 0.
  - frame_err <= ~rx_s.
  - rx_done <= 1 for exactly one cycle.
- After STOP: go to IDLE if rx_s == 1; go to BREAK if rx_s == 0.
- BREAK: wait for rx_s == 1, then go to IDLE. No start detection while the line is held low, so a break condition yields exactly one rx_done with frame_err = 1.
- Latency: rx_done rises on the clk edge of the b_tick that samples the stop-bit centre. That is about 10.5 bit periods plus 2 clk cycles after the start-bit falling edge on rx.
- Back-to-back frames: a new start edge is accepted in IDLE the cycle after the return from STOP. This must keep up with the transmitter sending continuously.
- d_out, parity_err and frame_err are registered and change only together with rx_done.
- Assertions:
  - rx_done is never high on two consecutive cycles.
  - State is always one of IDLE, START, DATA, PARITY, STOP, BREAK.
  - s_cnt never exceeds 15.

Test Plan:
- Loopback with the transmitter, PARITYSEL = 0, send 0xA5 (parity bit 0) -> one rx_done, d_out = 0xA5, parity_err = 0, frame_err = 0.
- Drive rx directly with 0xA5, parity bit 1, PARITYSEL = 0 -> d_out = 0xA5, parity_err = 1. Repeat with PARITYSEL = 1 -> parity_err = 0.
- Frame 0x3C with stop bit 0, then line held low for 3 bit times -> exactly one rx_done, d_out = 0x3C, frame_err = 1. Next frame 0x81 after the line goes high -> d_out = 0x81, frame_err = 0.
- rx low pulse of 4 b_ticks from IDLE -> no rx_done, state back in IDLE, outputs unchanged.
- Transmitter sends 0x00, 0xFF, 0x55 back-to-back with PARITYSEL = 1 -> three rx_done strobes, d_out = 0x00/0xFF/0x55 in order, all error flags 0.
- Assert resetn during DATA bit 4 of 0xC3, release it, then send 0x12 -> no strobe for 0xC3, outputs 0 during reset, one rx_done with d_out = 0x12.
